// File: rtl/uart_bus_master_pkg.sv
// Shared types for the UART bus master: register addresses, STATUS bit positions,
// byte-select codes, the FSM state type and a packed bus-request record.
package uart_bus_master_pkg;

    typedef enum logic [1:0] {
        ADR_BAUD   = 2'd0,
        ADR_CTRL   = 2'd1,
        ADR_STATUS = 2'd2,
        ADR_DATA   = 2'd3
    } uart_adr_e;

    localparam int unsigned ST_TX_FULL   = 0;
    localparam int unsigned ST_TX_EMPTY  = 1;
    localparam int unsigned ST_RX_FULL   = 2;
    localparam int unsigned ST_RX_EMPTY  = 3;
    localparam int unsigned ST_FRAME_ERR = 4;

    localparam logic [3:0] BS_BAUD = 4'b0011;
    localparam logic [3:0] BS_BYTE = 4'b0001;
    localparam logic [3:0] BS_READ = 4'b0000;

    typedef enum logic [2:0] {
        S_UNCFG,
        S_WR_BAUD,
        S_WR_CTRL,
        S_POLL,
        S_STAT,
        S_RX_RD,
        S_RX_CAP,
        S_TX_WR
    } state_e;

    typedef struct packed {
        logic        stb;
        logic        we;
        uart_adr_e   adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_req_t;

    localparam bus_req_t BUS_IDLE = '0;

    function automatic bus_req_t bus_rd(input uart_adr_e adr);
        bus_req_t r;
        r     = BUS_IDLE;
        r.stb = 1'b1;
        r.adr = adr;
        r.sel = BS_READ;
        return r;
    endfunction

    function automatic bus_req_t bus_wr(input uart_adr_e adr, input logic [3:0] sel,
                                        input logic [31:0] dat);
        bus_req_t r;
        r.stb = 1'b1;
        r.we  = 1'b1;
        r.adr = adr;
        r.sel = sel;
        r.dat = dat;
        return r;
    endfunction

endpackage

// File: rtl/uart_bus_master.sv
// Bus initiator for a UART slave: configures BAUD/CTRL, polls STATUS and moves
// bytes between valid/ready streams and the DATA register.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_UNCFG   | idle after reset, waiting for cfg_start_i
// S_WR_BAUD | BAUD write strobe on the bus
// S_WR_CTRL | CTRL write strobe on the bus
// S_POLL    | STATUS read strobe on the bus
// S_STAT    | STATUS data on dat_i; choose reconfig / RX / TX / re-poll
// S_RX_RD   | DATA read strobe on the bus
// S_RX_CAP  | DATA read data on dat_i, captured into the rx holding register
// S_TX_WR   | DATA write strobe with the stream byte; tx_ready_o pulses
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [1:0]  CTRL_INIT  = 2'b11
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_start_i,
    input  logic [15:0]           baud_div_i,
    output logic                  cfg_done_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  frame_err_o,
    output logic                  stb_o,
    output logic [1:0]            adr_o,
    output logic                  we_o,
    output logic [3:0]            byte_sel_o,
    output logic [31:0]           dat_o,
    input  logic [31:0]           dat_i
);

    state_e      state;
    bus_req_t    bus_q;
    logic [15:0] baud_q;
    logic        cfg_pend;

    // Only the STATUS bits that steer the FSM and the low DATA_WIDTH bits are consumed.
    logic unused_dat;
    assign unused_dat = ^dat_i;

    assign stb_o      = bus_q.stb;
    assign we_o       = bus_q.we;
    assign adr_o      = bus_q.adr;
    assign byte_sel_o = bus_q.sel;
    assign dat_o      = bus_q.dat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_UNCFG;
            bus_q       <= BUS_IDLE;
            baud_q      <= '0;
            cfg_pend    <= 1'b0;
            cfg_done_o  <= 1'b0;
            tx_ready_o  <= 1'b0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            bus_q       <= BUS_IDLE;
            tx_ready_o  <= 1'b0;
            frame_err_o <= 1'b0;

            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            // A late cfg_start_i is queued; it never interrupts the access in flight.
            if (cfg_start_i) begin
                baud_q     <= baud_div_i;
                cfg_done_o <= 1'b0;
                if (state != S_UNCFG) begin
                    cfg_pend <= 1'b1;
                end
            end

            case (state)
                S_UNCFG: begin
                    if (cfg_start_i) begin
                        state <= S_WR_BAUD;
                        bus_q <= bus_wr(ADR_BAUD, BS_BAUD, {16'b0, baud_div_i});
                    end
                end
                S_WR_BAUD: begin
                    state <= S_WR_CTRL;
                    bus_q <= bus_wr(ADR_CTRL, BS_BYTE, {30'b0, CTRL_INIT});
                end
                S_WR_CTRL: begin
                    state      <= S_POLL;
                    bus_q      <= bus_rd(ADR_STATUS);
                    cfg_done_o <= !(cfg_pend || cfg_start_i);
                end
                S_POLL: begin
                    state <= S_STAT;
                end
                S_STAT: begin
                    frame_err_o <= dat_i[ST_FRAME_ERR];
                    if (cfg_pend) begin
                        // A cfg_start_i arriving this very cycle still wins the baud value.
                        cfg_pend <= 1'b0;
                        state    <= S_WR_BAUD;
                        bus_q    <= bus_wr(ADR_BAUD, BS_BAUD,
                                           {16'b0, cfg_start_i ? baud_div_i : baud_q});
                    end else if (!dat_i[ST_RX_EMPTY] && !rx_valid_o) begin
                        state <= S_RX_RD;
                        bus_q <= bus_rd(ADR_DATA);
                    end else if (tx_valid_i && !dat_i[ST_TX_FULL]) begin
                        state      <= S_TX_WR;
                        bus_q      <= bus_wr(ADR_DATA, BS_BYTE, 32'(tx_data_i));
                        tx_ready_o <= 1'b1;
                    end else begin
                        state <= S_POLL;
                        bus_q <= bus_rd(ADR_STATUS);
                    end
                end
                S_RX_RD: begin
                    state <= S_RX_CAP;
                end
                S_RX_CAP: begin
                    rx_data_o  <= dat_i[DATA_WIDTH-1:0];
                    rx_valid_o <= 1'b1;
                    state      <= S_POLL;
                    bus_q      <= bus_rd(ADR_STATUS);
                end
                S_TX_WR: begin
                    state <= S_POLL;
                    bus_q <= bus_rd(ADR_STATUS);
                end
                default: begin
                    state <= S_UNCFG;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: a UART slave stand-in answers reads, a transaction-level
// model predicts every bus access and stream output, plus directed literal checks.
module tb_uart_bus_master;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        cfg_start_i = 1'b0;
    logic [15:0] baud_div_i = '0;
    logic        cfg_done_o;
    logic [7:0]  tx_data_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        frame_err_o;
    logic        stb_o;
    logic [1:0]  adr_o;
    logic        we_o;
    logic [3:0]  byte_sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = '0;

    uart_bus_master #(.DATA_WIDTH(8), .CTRL_INIT(2'b11)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_start_i(cfg_start_i), .baud_div_i(baud_div_i),
        .cfg_done_o(cfg_done_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .frame_err_o(frame_err_o), .stb_o(stb_o), .adr_o(adr_o),
        .we_o(we_o), .byte_sel_o(byte_sel_o), .dat_o(dat_o), .dat_i(dat_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // UART slave stand-in: read data appears the cycle after a read strobe, junk otherwise.
    logic [7:0]  status_val = 8'h0A;
    logic [31:0] data_val = 32'h0;
    bit          rand_slave = 0;
    logic        sl_rd;
    logic [1:0]  sl_adr;

    function automatic logic [31:0] rand_status();
        logic [7:0] s;
        s    = '0;
        s[0] = ($urandom_range(0, 3) == 0);
        s[1] = $urandom_range(0, 1) == 1;
        s[2] = $urandom_range(0, 1) == 1;
        s[3] = $urandom_range(0, 1) == 1;
        s[4] = ($urandom_range(0, 15) == 0);
        return {$urandom_range(0, 255), 16'h0, s} & 32'hFF00_00FF;
    endfunction

    initial forever begin
        @(negedge clk_i);
        sl_rd  = stb_o && !we_o;
        sl_adr = adr_o;
        @(posedge clk_i);
        #1;
        if (sl_rd && sl_adr == 2'd2)
            dat_i = rand_slave ? rand_status() : {24'h5A5A5A, status_val};
        else if (sl_rd && sl_adr == 2'd3)
            dat_i = rand_slave ? $urandom : data_val;
        else
            dat_i = $urandom;
    end

    // Transaction-level model: each access schedules the next one at a known cycle.
    typedef enum {K_BAUD, K_CTRL, K_STAT, K_DRD, K_DWR} kind_e;

    int          cyc = 0;
    int          acc_cyc, dec_cyc, cap_cyc, ferr_cyc;
    kind_e       acc_kind;
    logic [31:0] acc_dat;
    bit          m_cfgd, m_pend, m_done, m_rxv, acc_now, pend_before, rxv_now;
    logic [15:0] m_baud;
    logic [7:0]  m_rxd;
    kind_e       k_now;

    function automatic void sched(input int c, input kind_e k, input logic [31:0] d);
        acc_cyc  = c;
        acc_kind = k;
        acc_dat  = d;
    endfunction

    function automatic logic [1:0] k_adr(input kind_e k);
        case (k)
            K_BAUD:  return 2'd0;
            K_CTRL:  return 2'd1;
            K_STAT:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] k_sel(input kind_e k);
        case (k)
            K_BAUD:        return 4'b0011;
            K_CTRL, K_DWR: return 4'b0001;
            default:       return 4'b0000;
        endcase
    endfunction

    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            acc_cyc = -1; dec_cyc = -1; cap_cyc = -1; ferr_cyc = -1;
            m_cfgd = 0; m_pend = 0; m_done = 0; m_rxv = 0; m_baud = '0; m_rxd = '0;
            chk("reset_ctrl_outputs", {stb_o, we_o, adr_o, byte_sel_o, tx_ready_o,
                                       frame_err_o, cfg_done_o, rx_valid_o}, 32'h0);
            chk("reset_dat_o", dat_o, 32'h0);
            chk("reset_rx_data", rx_data_o, 32'h0);
        end else begin
            acc_now = (cyc == acc_cyc);
            k_now   = acc_kind;
            chk("stb", stb_o, acc_now);
            if (acc_now && stb_o) begin
                chk("adr", adr_o, k_adr(k_now));
                chk("we", we_o, (k_now == K_BAUD || k_now == K_CTRL || k_now == K_DWR));
                chk("byte_sel", byte_sel_o, k_sel(k_now));
                if (we_o) chk("dat_o", dat_o, acc_dat);
            end
            chk("tx_ready", tx_ready_o, acc_now && k_now == K_DWR);
            chk("frame_err", frame_err_o, cyc == ferr_cyc);
            chk("cfg_done", cfg_done_o, m_done);
            chk("rx_valid", rx_valid_o, m_rxv);
            if (m_rxv) chk("rx_data", rx_data_o, m_rxd);

            rxv_now     = m_rxv;
            pend_before = m_pend;
            if (m_rxv && rx_ready_i) m_rxv = 0;
            if (cyc == cap_cyc) begin
                m_rxd = dat_i[7:0];
                m_rxv = 1;
            end
            if (cfg_start_i) begin
                m_baud = baud_div_i;
                m_done = 0;
            end
            if (acc_now) begin
                case (k_now)
                    K_BAUD: sched(cyc + 1, K_CTRL, 32'd3);
                    K_CTRL: sched(cyc + 1, K_STAT, 32'd0);
                    K_STAT: dec_cyc = cyc + 1;
                    K_DRD: begin
                        cap_cyc = cyc + 1;
                        sched(cyc + 2, K_STAT, 32'd0);
                    end
                    K_DWR:  sched(cyc + 1, K_STAT, 32'd0);
                    default: ;
                endcase
            end
            if (cyc == dec_cyc) begin
                if (dat_i[4]) ferr_cyc = cyc + 1;
                if (pend_before) begin
                    sched(cyc + 1, K_BAUD, {16'h0, m_baud});
                    m_pend = 0;
                end else if (!dat_i[3] && !rxv_now)
                    sched(cyc + 1, K_DRD, 32'd0);
                else if (tx_valid_i && !dat_i[0])
                    sched(cyc + 1, K_DWR, {24'h0, tx_data_i});
                else
                    sched(cyc + 1, K_STAT, 32'd0);
            end
            if (cfg_start_i) begin
                if (!m_cfgd) begin
                    m_cfgd = 1;
                    sched(cyc + 1, K_BAUD, {16'h0, baud_div_i});
                end else if (!(cyc == dec_cyc && pend_before)) begin
                    m_pend = 1;
                end
            end
            if (acc_now && k_now == K_CTRL) m_done = !m_pend;
        end
    end

    task automatic drive_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_acc(input logic [1:0] a, input logic w, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            sample();
            if (stb_o && adr_o == a && we_o == w) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_seen"}, ok, 1'b1);
    endtask

    initial begin
        #(600_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    int  cnt_a, cnt_b;
    bit  seen_ready, found;

    initial begin
        #3 rst_ni = 1'b0;
        sample();
        sample();
        chk("reset_literal", {stb_o, cfg_done_o, tx_ready_o, rx_valid_o, dat_o[15:0]}, 32'h0);
        drive_edge();
        rst_ni = 1'b1;
        repeat (3) drive_edge();

        // configuration
        cfg_start_i = 1'b1;
        baud_div_i  = 16'd434;
        drive_edge();
        cfg_start_i = 1'b0;
        wait_acc(2'd0, 1'b1, "cfg_baud");
        chk("cfg_baud_dat", dat_o, 32'd434);
        chk("cfg_baud_sel", byte_sel_o, 4'b0011);
        sample();
        chk("cfg_ctrl", {stb_o, we_o, adr_o, byte_sel_o}, {1'b1, 1'b1, 2'd1, 4'b0001});
        chk("cfg_ctrl_dat", dat_o, 32'd3);
        sample();
        chk("cfg_done_lit", cfg_done_o, 1'b1);
        chk("cfg_first_poll", {stb_o, we_o, adr_o}, {1'b1, 1'b0, 2'd2});

        // single TX byte
        drive_edge();
        status_val = 8'h0A;
        tx_data_i  = 8'hA5;
        tx_valid_i = 1'b1;
        wait_acc(2'd3, 1'b1, "tx_write");
        chk("tx_write_dat", dat_o, 32'h0000_00A5);
        chk("tx_ready_lit", tx_ready_o, 1'b1);
        drive_edge();
        tx_valid_i = 1'b0;

        // TX full: polling only, one STATUS read every two cycles
        status_val = 8'h09;
        tx_data_i  = 8'h5A;
        tx_valid_i = 1'b1;
        repeat (4) drive_edge();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (stb_o && adr_o == 2'd3) cnt_a++;
            if (stb_o && adr_o == 2'd2) cnt_b++;
        end
        chk("txfull_no_write", cnt_a, 0);
        chk("txfull_poll_rate", cnt_b, 10);
        drive_edge();
        status_val = 8'h0A;
        wait_acc(2'd3, 1'b1, "txfull_release");
        chk("txfull_release_dat", dat_o, 32'h5A);
        drive_edge();
        tx_valid_i = 1'b0;

        // RX byte held while consumer stalls
        status_val = 8'h02;
        data_val   = 32'hFFFF_FF3C;
        rx_ready_i = 1'b0;
        wait_acc(2'd3, 1'b0, "rx_read");
        sample();
        sample();
        chk("rx_valid_lit", rx_valid_o, 1'b1);
        chk("rx_data_lit", rx_data_o, 8'h3C);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (stb_o && adr_o == 2'd3) cnt_a++;
            if (rx_valid_o) cnt_b++;
        end
        chk("rx_hold_no_read", cnt_a, 0);
        chk("rx_hold_valid", cnt_b, 5);
        drive_edge();
        status_val = 8'h0A;
        rx_ready_i = 1'b1;
        repeat (6) drive_edge();

        // RX and TX both possible: read first
        status_val = 8'h02;
        data_val   = 32'h0000_0011;
        tx_data_i  = 8'h77;
        tx_valid_i = 1'b1;
        rx_ready_i = 1'b0;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            sample();
            if (stb_o && adr_o == 2'd3) begin
                found = 1;
                break;
            end
        end
        chk("both_data_seen", found, 1'b1);
        chk("both_read_first", we_o, 1'b0);
        wait_acc(2'd3, 1'b1, "both_write");
        chk("both_write_dat", dat_o, 32'h77);
        drive_edge();
        tx_valid_i = 1'b0;
        status_val = 8'h0A;
        rx_ready_i = 1'b1;
        repeat (6) drive_edge();

        // frame error pulse
        status_val = 8'h1A;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (frame_err_o) begin
                found = 1;
                break;
            end
        end
        chk("frame_err_seen", found, 1'b1);
        sample();
        chk("frame_err_width", frame_err_o, 1'b0);
        drive_edge();
        status_val = 8'h0A;
        repeat (4) drive_edge();

        // reconfigure while a DATA read is on the bus
        status_val = 8'h02;
        data_val   = 32'h55;
        rx_ready_i = 1'b1;
        wait_acc(2'd2, 1'b0, "reconf_poll");
        drive_edge();
        drive_edge();
        cfg_start_i = 1'b1;
        baud_div_i  = 16'h1234;
        status_val  = 8'h0A;
        sample();
        chk("reconf_rxrd_active", {stb_o, we_o, adr_o}, {1'b1, 1'b0, 2'd3});
        drive_edge();
        cfg_start_i = 1'b0;
        sample();
        chk("reconf_done_low", cfg_done_o, 1'b0);
        wait_acc(2'd0, 1'b1, "reconf_baud");
        chk("reconf_baud_dat", dat_o, 32'h1234);
        repeat (6) drive_edge();

        // reset in the middle of a TX write
        tx_data_i  = 8'hC3;
        tx_valid_i = 1'b1;
        wait_acc(2'd3, 1'b1, "rst_tx");
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_tx_outputs", {stb_o, we_o, adr_o, byte_sel_o, tx_ready_o, cfg_done_o,
                                   rx_valid_o, frame_err_o}, 32'h0);
        chk("rst_mid_tx_dat", dat_o, 32'h0);
        repeat (3) drive_edge();
        rst_ni = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (stb_o || tx_ready_o || cfg_done_o) cnt_a++;
        end
        chk("post_reset_idle", cnt_a, 0);

        // randomized traffic
        drive_edge();
        rand_slave  = 1;
        cfg_start_i = 1'b1;
        baud_div_i  = 16'($urandom);
        drive_edge();
        cfg_start_i = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            sample();
            seen_ready = tx_ready_o;
            drive_edge();
            cfg_start_i = ($urandom_range(0, 199) == 0);
            if (cfg_start_i) baud_div_i = 16'($urandom);
            if (tx_valid_i && seen_ready) tx_valid_i = 1'b0;
            if (!tx_valid_i && $urandom_range(0, 3) == 0) begin
                tx_valid_i = 1'b1;
                tx_data_i  = 8'($urandom);
            end
            rx_ready_i = ($urandom_range(0, 2) == 0);
        end
        cfg_start_i = 1'b0;
        repeat (5) drive_edge();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
